// File: rtl/lote_frame_tx.sv
// lote_frame_tx -- transmitter end of the lot-sensor serial link.
//
// Takes one 5-bit lot sensor word (a..e) through a valid/ready handshake and
// sends it on a single line. The frame is start(0), a, b, c, d, e (MSB first),
// parity, stop(1). Every bit is held for CLKS_PER_BIT clock cycles.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (1 or more)
//   PARITY_ODD    0: parity = XOR of the data bits, 1: its inverse
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   lote        sensor word, bit4 = a ... bit0 = e
//   lote_valid  lote holds a word to send
//   lote_ready  a word can be accepted this cycle (IDLE and not in reset)
//   tx          serial line, idles high, registered
//   busy        a frame is in progress
//   frame_done  one-cycle pulse in the first IDLE cycle after a stop bit
module lote_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] lote,
  input  logic       lote_valid,
  output logic       lote_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [4:0]    shreg, shreg_n;
  logic          parity_bit, parity_n;
  logic          tx_q, tx_n;
  logic          done_q, done_n;
  logic          bit_last;

  assign bit_last   = (cnt == CNT_LAST);
  assign lote_ready = (state == IDLE) & ~rst;
  assign busy       = (state != IDLE);
  assign tx         = tx_q;
  assign frame_done = done_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shreg_n  = shreg;
    parity_n = parity_bit;
    done_n   = 1'b0;

    if (state != IDLE) begin
      cnt_n = bit_last ? '0 : cnt + CW'(1);
    end

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        // Reset priority over an accept is handled in the register process.
        if (lote_valid) begin
          shreg_n  = lote;
          parity_n = (^lote) ^ PARITY_ODD;
          state_n  = START;
        end
      end
      START: begin
        if (bit_last) state_n = DATA;
      end
      DATA: begin
        if (bit_last) begin
          if (idx == 3'd4) begin
            idx_n   = '0;
            state_n = PARITY;
          end else begin
            // Shift the next data bit into position 4 (MSB first on the line).
            idx_n   = idx + 3'd1;
            shreg_n = {shreg[3:0], 1'b0};
          end
        end
      end
      PARITY: begin
        if (bit_last) state_n = STOP;
      end
      STOP: begin
        if (bit_last) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // tx is registered from the next state so the line changes exactly on the
    // edge where the state does, with no combinational path to the pin.
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[4];
      PARITY:  tx_n = parity_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      parity_bit <= parity_n;
      tx_q       <= tx_n;
      done_q     <= done_n;
    end
  end

endmodule

// File: tb/tb_lote_frame_tx.sv
// Bench for lote_frame_tx. Three instances share one stimulus:
//   u_even  CLKS_PER_BIT=4, even parity
//   u_odd   CLKS_PER_BIT=4, odd parity
//   u_fast  CLKS_PER_BIT=1, even parity
// A frame-timeline model (per instance: frame bit pattern plus elapsed cycles)
// predicts every output and is compared each cycle on the falling edge.
// Directed scenarios pin the model with literal frame patterns.
module tb_lote_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lote_valid = 1'b1;
  logic [4:0] lote = 5'b01111;
  logic [2:0] ready_w, tx_w, busy_w, done_w;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  lote_frame_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .lote(lote), .lote_valid(lote_valid),
    .lote_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0])
  );

  lote_frame_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .lote(lote), .lote_valid(lote_valid),
    .lote_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1])
  );

  lote_frame_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) u_fast (
    .clk(clk), .rst(rst), .lote(lote), .lote_valid(lote_valid),
    .lote_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2])
  );

  function automatic int cpb_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic bit odd_of(input int k);
    return (k == 1);
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is the 8-bit pattern {start, a..e, parity, stop}; elapsed counts
  // cycles since the accept edge, so the current bit is elapsed / CLKS_PER_BIT.
  bit         m_act[3];
  int         m_el[3];
  logic [7:0] m_fb[3];
  bit         m_dn[3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_act[k] <= 1'b0;
        m_dn[k]  <= 1'b0;
      end else if (!m_act[k]) begin
        m_dn[k] <= 1'b0;
        if (lote_valid) begin
          m_act[k] <= 1'b1;
          m_el[k]  <= 0;
          m_fb[k]  <= {1'b0, lote, (^lote) ^ odd_of(k), 1'b1};
        end
      end else if (m_el[k] == 8 * cpb_of(k) - 1) begin
        m_act[k] <= 1'b0;
        m_dn[k]  <= 1'b1;
      end else begin
        m_el[k] <= m_el[k] + 1;
        m_dn[k] <= 1'b0;
      end
    end
    chk_en <= 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        logic exp_tx;
        exp_tx = m_act[k] ? m_fb[k][7 - m_el[k] / cpb_of(k)] : 1'b1;
        check($sformatf("u%0d_tx", k), tx_w[k], exp_tx);
        check($sformatf("u%0d_busy", k), busy_w[k], m_act[k]);
        check($sformatf("u%0d_done", k), done_w[k], m_dn[k]);
        check($sformatf("u%0d_ready", k), ready_w[k], !m_act[k] && !rst);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a cycle where instance k will accept, then steps past
  // the accept edge.
  task automatic wait_accept(input int k);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (ready_w[k] && lote_valid) got = 1'b1;
    end
    check("accept_wait", got, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Called just after an accept edge: samples the whole frame plus the
  // following IDLE cycle of instance k and checks it against exp_bits.
  task automatic frame_check(input string name, input int k, input logic [7:0] exp_bits);
    logic [7:0] bits;
    bit         stable;
    int         busy_cnt, done_cnt, n, c;
    logic       done_last, tx_tail;
    c = cpb_of(k);
    n = 8 * c;
    stable = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    bits = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i % c == 0) bits[7 - i / c] = tx_w[k];
      else if (tx_w[k] !== bits[7 - i / c]) stable = 1'b0;
      busy_cnt += int'(busy_w[k]);
      done_cnt += int'(done_w[k]);
    end
    @(negedge clk);
    done_last = done_w[k];
    tx_tail   = tx_w[k];
    done_cnt += int'(done_w[k]);
    check({name, "_bits"}, bits, exp_bits);
    check({name, "_held"}, stable, 1'b1);
    check({name, "_busy_cycles"}, busy_cnt, n);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_done_last"}, done_last, 1'b1);
    check({name, "_tx_idle"}, tx_tail, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dc;

    // Reset held with lote_valid high.
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", tx_w[0], 1'b1);
      check("rst_busy", busy_w[0], 1'b0);
      check("rst_ready", ready_w[0], 1'b0);
      check("rst_done", done_w[0], 1'b0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("release_ready", ready_w[0], 1'b1);
    tick();
    lote_valid = 1'b0;
    fork
      frame_check("compromised_even", 0, 8'b00111101);
      frame_check("compromised_odd", 1, 8'b00111111);
    join

    // Back-to-back with lote_valid held high.
    tick();
    lote = 5'b10110;
    lote_valid = 1'b1;
    wait_accept(0);
    lote = 5'b11101;
    frame_check("b2b_first", 0, 8'b01011011);
    check("b2b_ready_in_done", ready_w[0], 1'b1);
    tick();
    lote_valid = 1'b0;
    frame_check("b2b_second", 0, 8'b01110101);

    // Parity modes.
    tick();
    lote = 5'b11111;
    lote_valid = 1'b1;
    wait_accept(0);
    lote_valid = 1'b0;
    fork
      frame_check("par_even_11111", 0, 8'b01111111);
      frame_check("par_odd_11111", 1, 8'b01111101);
    join
    tick();
    lote = 5'b00000;
    lote_valid = 1'b1;
    wait_accept(0);
    lote_valid = 1'b0;
    fork
      frame_check("par_even_00000", 0, 8'b00000001);
      frame_check("par_odd_00000", 1, 8'b00000011);
    join

    // Input stability: lote toggles every cycle during the frame.
    tick();
    lote = 5'b11011;
    lote_valid = 1'b1;
    wait_accept(0);
    lote_valid = 1'b0;
    fork
      frame_check("stable_11011", 0, 8'b01101101);
      begin
        repeat (32) begin
          lote = ~lote;
          tick();
        end
      end
    join

    // Reset during data bit c, then a clean frame.
    tick();
    lote = 5'b10101;
    lote_valid = 1'b1;
    wait_accept(0);
    lote_valid = 1'b0;
    repeat (13) tick();
    @(negedge clk);
    check("mid_bit_c", tx_w[0], 1'b1);
    check("mid_busy", busy_w[0], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", tx_w[0], 1'b1);
    check("mid_rst_busy", busy_w[0], 1'b0);
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      dc += int'(done_w[0]);
    end
    check("mid_rst_no_done", dc, 0);
    tick();
    lote = 5'b01111;
    lote_valid = 1'b1;
    wait_accept(0);
    lote_valid = 1'b0;
    frame_check("after_rst", 0, 8'b00111101);

    // Random traffic, occasional resets; the model checks every cycle.
    repeat (400) begin
      tick();
      lote       = 5'($urandom);
      lote_valid = 1'($urandom_range(0, 1));
      rst        = ($urandom_range(0, 63) == 0);
    end
    tick();
    rst = 1'b0;
    lote_valid = 1'b0;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lote_frame_tx.md
Name: lote_frame_tx

Overview:
- Transmitter end of the lot-sensor serial link.
- Accepts one 5-bit lot sensor word (sensors a..e) through a valid/ready handshake and sends it on a single line as a framed serial word.
- The frame is: start bit, 5 data bits, parity bit, stop bit.
- The receiver at the far end rebuilds the word and feeds the lot classifiers (compromised / approved / rejected).

Parameters:
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx. Legal range is 1 or more; 4 is the simulation default.
- PARITY_ODD, 0, selects the parity bit. 0 means even parity (parity bit = XOR of the 5 data bits). 1 means odd parity (the inverse).

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- lote  input  5  sensor word. bit4 = a, bit3 = b, bit2 = c, bit1 = d, bit0 = e.
- lote_valid  input  1  lote holds a word to send.
- lote_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse after a stop bit completes.

Behaviour:
- Clocking and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: tx=1, busy=0, frame_done=0, state=IDLE, counters=0, shift register=0.
- lote_ready = (state==IDLE) & ~rst, so it is 0 whenever rst is high.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept rule:
  - A word is accepted at a rising edge where lote_valid & lote_ready.
  - At that edge, lote is captured into the shift register, the parity bit is computed from the captured value, and the state goes to START.
  - No transfer occurs when lote_valid=0 or when not in IDLE. lote and lote_valid are ignored outside IDLE.
  - Changes to lote after acceptance have no effect on the frame in progress.
- Bit timing:
  - A cycle counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - The state advances when the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
  - Each bit is held on tx for exactly CLKS_PER_BIT cycles.
- Transmitted sequence:
  - START: tx=0.
  - DATA: tx = a, b, c, d, e in that order (MSB first). A 3-bit index counts 0..4; DATA exits to PARITY after index 4.
  - PARITY: tx = parity bit.
  - STOP: tx=1.
  - STOP exits to IDLE.
- tx is registered and glitch-free.
- Latency: tx falls at the first edge after the accept edge. A frame occupies 8*CLKS_PER_BIT cycles.
- busy is 1 from the cycle after accept through the last STOP cycle, and 0 in IDLE.
- frame_done:
  - Registered; high for exactly the first IDLE cycle following STOP.
  - In that cycle lote_ready=1, so a back-to-back word can be accepted.
  - Minimum frame period is 8*CLKS_PER_BIT+1 cycles. Between frames the line stays high for at least CLKS_PER_BIT+1 cycles.
- Reset mid-frame:
  - At the next edge: state=IDLE and tx=1; the frame is aborted.
  - No frame_done is generated. The partial frame is not resumed.
  - The first word after reset is sent in full.
- Simultaneous rst and lote_valid: rst wins; the word is not accepted.
- CLKS_PER_BIT=1: each bit lasts 1 cycle and the same rules apply.

Test Plan:
- Reset check (CLKS_PER_BIT=4):
  - Stimulus: hold rst=1 for 3 cycles with lote_valid=1.
  - Required: tx=1, busy=0, lote_ready=0, frame_done=0. After release lote_ready=1 and the first accept is on the first edge with rst=0.
- Compromised pattern (a=0):
  - Stimulus: send lote=5'b01111, even parity.
  - Required: tx = 0,0,1,1,1,1,0,1, each held 4 cycles (32 cycles total). busy=1 for those 32 cycles. frame_done pulses once in cycle 33 after accept.
- Parity modes:
  - Stimulus: send 5'b11111.
  - Required: parity bit 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1. For 5'b00000 the parity bit is 0 and 1 respectively.
- Back-to-back:
  - Stimulus: lote_valid held high with word 5'b10110 then 5'b11101.
  - Required: the second word is accepted in the frame_done cycle. tx is high for exactly 5 cycles between frames (4 stop + 1 idle). The second frame carries 1,1,1,0,1.
- Input stability:
  - Stimulus: toggle lote every cycle during a frame of 5'b11011.
  - Required: transmitted data bits stay 1,1,0,1,1 and the parity bit is 0.
- Reset mid-DATA:
  - Stimulus: assert rst for 1 cycle during data bit c.
  - Required: tx=1 at the next edge, no frame_done pulse. The next word 5'b01111 is transmitted complete and correct.
